uart_tx_seq: RTL and testbench



---
 rtl/uart_tx_seq.sv | 129 ++++++++++++
 tb/tb_uart_tx_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_seq.sv
// Serial transmit stage: on start, sends MSG_LEN upstream bytes as back-to-back 8N1 frames,
// pulsing next as each byte is latched so the upstream ROM pointer advances.
module uart_tx_seq #(
   parameter int CLKS_PER_BIT = 868,
   parameter int MSG_LEN      = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       next,
   output logic       busy,
   output logic       done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CNT_W  = $clog2(MSG_LEN + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  BYTE_LAST = CNT_W'(MSG_LEN);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [CNT_W-1:0]  byte_q, byte_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              next_q, next_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              bit_end;

   assign bit_end = (baud_q == BAUD_LAST);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d = state_q;
      baud_d  = '0;
      bit_d   = bit_q;
      byte_d  = byte_q;
      shift_d = shift_q;
      next_d  = 1'b0;
      done_d  = 1'b0;

      if (state_q != IDLE) begin
         baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               shift_d = data;
               byte_d  = CNT_W'(1);
               next_d  = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         STOP: begin
            // Latching the next byte here is what makes frames back-to-back with no idle gap.
            if (bit_end) begin
               if (byte_q < BYTE_LAST) begin
                  shift_d = data;
                  byte_d  = byte_q + CNT_W'(1);
                  next_d  = 1'b1;
                  state_d = START;
               end else begin
                  byte_d  = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // tx is registered, so it is derived from the state being entered.
      tx_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         next_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         next_q  <= next_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx   = tx_q;
   assign next = next_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_uart_tx_seq.sv
// Scoreboard bench for uart_tx_seq: a 7-byte instance fed by a ROM model and decoded by a
// UART receiver, plus a 1-byte instance checked cycle by cycle against the 8N1 frame rule.
module tb_uart_tx_seq;

   localparam int CPB   = 4;
   localparam int LEN   = 7;
   localparam int FRAME = 10 * CPB;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       rst_s  = 1'b0;
   logic       start  = 1'b1;
   logic [7:0] data;
   logic       tx, next, busy, done;
   logic       start1 = 1'b1;
   logic [7:0] data1  = '0;
   logic       tx1, next1, busy1, done1;

   int cyc     = 0;
   int n_tests = 0;
   int n_fail  = 0;

   // Upstream ROM model: pointer advances on every next pulse and is never rewound by rst.
   logic [7:0] rom [LEN];
   int         ptr = 0;

   logic [7:0] exp_q  [$];
   int         msg_q  [$];
   logic [3:0] exp1_q [$];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_s <= rst;
      if (next) ptr <= (ptr + 1) % LEN;
   end

   assign data = rom[ptr];

   uart_tx_seq #(.CLKS_PER_BIT(CPB), .MSG_LEN(LEN)) u_dut (
      .clk(clk), .rst(rst), .start(start), .data(data),
      .tx(tx), .next(next), .busy(busy), .done(done)
   );

   uart_tx_seq #(.CLKS_PER_BIT(CPB), .MSG_LEN(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .data(data1),
      .tx(tx1), .next(next1), .busy(busy1), .done(done1)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor for the 7-byte instance: frame receiver plus message timing.
   bit             armed = 0, in_frame = 0, in_msg = 0, busy_prev = 0;
   int             ns = 0, rise = 0, nn = 0;
   logic [FRAME-1:0] samp;

   always @(negedge clk) begin
      bit         fresh;
      bit         shape_ok;
      logic [7:0] rx;
      if (rst_s) begin
         check("reset_outputs", {tx, next, busy, done}, 4'b1000);
         armed = 1; in_frame = 0; in_msg = 0; busy_prev = 0;
      end else if (armed) begin
         fresh = 0;
         if (!in_frame && !tx) begin
            in_frame = 1; ns = 0; fresh = 1;
            check("next_at_start_bit", next, 1);
         end
         if (next) check("next_only_at_frame_start", fresh, 1);
         if (in_frame) begin
            samp[ns] = tx;
            ns++;
            if (ns == FRAME) begin
               shape_ok = 1;
               for (int b = 0; b < 10; b++)
                  for (int s = 1; s < CPB; s++)
                     if (samp[b*CPB+s] !== samp[b*CPB]) shape_ok = 0;
               if (samp[9*CPB] !== 1'b1) shape_ok = 0;
               for (int i = 0; i < 8; i++) rx[i] = samp[(i+1)*CPB];
               check("frame_shape", shape_ok, 1);
               check("rx_queue_nonempty", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) check("rx_byte", rx, exp_q.pop_front());
               in_frame = 0;
            end
         end
         if (busy && !busy_prev) begin
            check("msg_queue_nonempty", msg_q.size() > 0, 1);
            if (msg_q.size() > 0) check("busy_start_cycle", cyc, msg_q.pop_front());
            rise = cyc; in_msg = 1; nn = 0;
         end
         if (next && in_msg) begin
            check("next_spacing", cyc, rise + nn * FRAME);
            nn++;
         end
         if (!busy && busy_prev) check("busy_falls_with_done", done, 1);
         if (done) begin
            check("done_inside_message", in_msg, 1);
            if (in_msg) begin
               check("done_cycle", cyc, rise + LEN * FRAME);
               check("next_count", nn, LEN);
            end
            check("done_busy_tx", {busy, tx}, 2'b01);
            in_msg = 0;
         end
         busy_prev = busy;
      end
   end

   // Monitor for the 1-byte instance: pops one expected output vector per cycle.
   bit armed1 = 0;

   always @(negedge clk) begin
      if (rst_s) begin
         check("dut1_reset", {tx1, next1, busy1, done1}, 4'b1000);
         armed1 = 1;
      end else if (armed1) begin
         if (exp1_q.size() > 0) check("dut1_cycle", {tx1, next1, busy1, done1}, exp1_q.pop_front());
         else                   check("dut1_idle",  {tx1, next1, busy1, done1}, 4'b1000);
      end
   end

   task automatic send1(input logic [7:0] b);
      @(posedge clk); #1;
      data1  = b;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      // Expected {tx, next, busy, done}: start bit, 8 data bits LSB first, stop bit, then done.
      for (int c = 0; c < FRAME; c++) begin
         int   bi;
         logic t;
         bi = c / CPB;
         t  = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
         exp1_q.push_back({t, c == 0, 1'b1, 1'b0});
      end
      exp1_q.push_back(4'b1001);
      for (int i = 0; i < FRAME + 20 && exp1_q.size() > 0; i++) @(negedge clk);
      check("dut1_drained", exp1_q.size() == 0, 1);
   endtask

   // A message is the next LEN ROM entries starting at the current pointer.
   task automatic push_msg();
      for (int j = 0; j < LEN; j++) exp_q.push_back(rom[(ptr + j) % LEN]);
      msg_q.push_back(cyc + 1);
   endtask

   task automatic send_msg();
      @(posedge clk); #1;
      push_msg();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic pulse_start_after(input int k);
      repeat (k) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 0;
      for (int i = 0; i < 2 * LEN * FRAME && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      check("done_timeout", seen, 1);
   endtask

   initial begin
      for (int i = 0; i < LEN; i++) rom[i] = 8'((i + 1) * 17);

      // Reset held three cycles with start high: nothing may begin.
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      start  = 1'b0;
      start1 = 1'b0;
      repeat (3) @(posedge clk);

      send1(8'hA5);
      repeat (3) send1(8'($urandom));

      // Full message 0x11..0x77.
      send_msg();
      wait_done();

      // Start pulsed during the data bits of byte 3 is ignored.
      send_msg();
      pulse_start_after(83 + $urandom_range(0, 31));
      wait_done();

      // Random ROM contents, random gaps, occasional ignored start pulses.
      for (int m = 0; m < 6; m++) begin
         for (int i = 0; i < LEN; i++) rom[i] = 8'($urandom);
         repeat ($urandom_range(0, 5)) @(posedge clk);
         send_msg();
         if ($urandom_range(0, 1) == 1) pulse_start_after($urandom_range(1, 250));
         wait_done();
      end

      // Reset during a data bit of byte 2; the next message starts at the advanced pointer.
      send_msg();
      repeat (44 + $urandom_range(0, 30)) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      msg_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      send_msg();
      wait_done();

      // Start held high across done: the second message starts the cycle after done.
      send_msg();
      repeat (100 + $urandom_range(0, 100)) @(posedge clk);
      #1 start = 1'b1;
      wait_done();
      push_msg();
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();

      repeat (20) @(posedge clk);
      check("scoreboard_drained", exp_q.size() + msg_q.size() + exp1_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
